// File: rtl/tl_a_arbiter_rr.sv
// Round-robin arbiter merging N_REQ TileLink-UL A channels onto one A channel.
// Multi-beat A messages hold the grant until their last beat. The A source is widened
// with the requester index, and D responses are routed back using that index.
// Outstanding messages are tracked per requester and capped at MAX_OUT.
//
// Handshake rule (A and D, every port): a beat transfers on a clock edge where valid and
// ready are both high. Here valid never depends on ready. Ready may depend on valid.
module tl_a_arbiter_rr #(
  parameter int N_REQ   = 2,
  parameter int MAX_OUT = 4,
  localparam int IDX_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      a_in_valid,
  output logic [N_REQ-1:0]      a_in_ready,
  input  logic [3*N_REQ-1:0]    a_in_opcode,
  input  logic [3*N_REQ-1:0]    a_in_size,
  input  logic [4*N_REQ-1:0]    a_in_source,
  input  logic [30*N_REQ-1:0]   a_in_address,
  input  logic [4*N_REQ-1:0]    a_in_mask,
  input  logic [32*N_REQ-1:0]   a_in_data,
  output logic                  a_out_valid,
  input  logic                  a_out_ready,
  output logic [2:0]            a_out_opcode,
  output logic [2:0]            a_out_size,
  output logic [4+IDX_W-1:0]    a_out_source,
  output logic [29:0]           a_out_address,
  output logic [3:0]            a_out_mask,
  output logic [31:0]           a_out_data,
  input  logic                  d_in_valid,
  output logic                  d_in_ready,
  input  logic [2:0]            d_in_opcode,
  input  logic [2:0]            d_in_size,
  input  logic [4+IDX_W-1:0]    d_in_source,
  output logic [N_REQ-1:0]      d_out_valid,
  input  logic [N_REQ-1:0]      d_out_ready,
  output logic [3:0]            d_out_source,
  output logic [4*N_REQ-1:0]    outstanding,
  output logic                  dbg_state,
  output logic [IDX_W-1:0]      dbg_rr_ptr
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [5:0]       beat_cnt_q, beat_cnt_d;
  logic [5:0]       d_cnt_q, d_cnt_d;
  logic [3:0]       out_cnt_q [N_REQ];
  logic [3:0]       out_cnt_d [N_REQ];

  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] idle_gnt, grant;
  logic             idle_found;
  logic             a_fire, a_last;
  logic [5:0]       cur_beats, d_beats;
  logic [IDX_W-1:0] d_idx;
  logic             d_ok, d_fire, d_last;
  logic [N_REQ-1:0] ovf_err, unf_err;
  logic [3:0]       sel_source;

  // Number of beats in an A message: only Put/Arithmetic/Logical opcodes carry data.
  function automatic logic [5:0] a_beats(input logic [2:0] op, input logic [2:0] sz);
    if (op <= 3'd3 && sz > 3'd2) return 6'd1 << (sz - 3'd2);
    return 6'd1;
  endfunction

  // Number of beats in a D message: only AccessAckData carries data.
  function automatic logic [5:0] dd_beats(input logic [2:0] op, input logic [2:0] sz);
    if (op == 3'd1 && sz > 3'd2) return 6'd1 << (sz - 3'd2);
    return 6'd1;
  endfunction

  // State register and all datapath flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      d_cnt_q    <= '0;
      for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      d_cnt_q    <= d_cnt_d;
      for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
    end
  end

  // Idle-time grant: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    int j;
    j          = 0;
    idle_gnt   = '0;
    idle_found = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = a_in_valid[i] && (out_cnt_q[i] < 4'(MAX_OUT));
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!idle_found && eligible[j]) begin
        idle_found = 1'b1;
        idle_gnt   = IDX_W'(j);
      end
    end
  end

  // Output decode: the grant is locked during a burst and combinational in idle.
  always_comb begin
    grant         = (state_q == ST_BURST) ? grant_q : idle_gnt;
    a_out_valid   = (state_q == ST_BURST) ? a_in_valid[grant_q] : idle_found;
    a_in_ready    = '0;
    a_out_opcode  = '0;
    a_out_size    = '0;
    sel_source    = '0;
    a_out_address = '0;
    a_out_mask    = '0;
    a_out_data    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        a_in_ready[i] = a_out_ready && ((state_q == ST_BURST) || idle_found);
        a_out_opcode  = a_in_opcode[3*i +: 3];
        a_out_size    = a_in_size[3*i +: 3];
        sel_source    = a_in_source[4*i +: 4];
        a_out_address = a_in_address[30*i +: 30];
        a_out_mask    = a_in_mask[4*i +: 4];
        a_out_data    = a_in_data[32*i +: 32];
      end
    end
    a_out_source = {grant, sel_source};
    for (int i = 0; i < N_REQ; i++) outstanding[4*i +: 4] = out_cnt_q[i];
    dbg_state  = state_q;
    dbg_rr_ptr = rr_ptr_q;
  end

  // Next-state logic for the burst FSM and the round-robin pointer.
  always_comb begin
    a_fire     = a_out_valid && a_out_ready;
    cur_beats  = a_beats(a_out_opcode, a_out_size);
    a_last     = a_fire && ((state_q == ST_BURST) ? (beat_cnt_q == 6'd1) : (cur_beats == 6'd1));
    state_d    = state_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (a_fire && cur_beats != 6'd1) begin
          state_d    = ST_BURST;
          grant_d    = grant;
          beat_cnt_d = cur_beats - 6'd1;
        end
      end
      default: begin
        if (a_fire) begin
          beat_cnt_d = beat_cnt_q - 6'd1;
          if (beat_cnt_q == 6'd1) state_d = ST_IDLE;
        end
      end
    endcase
    if (a_last) rr_ptr_d = (int'(grant) == N_REQ - 1) ? '0 : grant + IDX_W'(1);
  end

  // D routing by the index in the upper source bits, plus D beat counting.
  always_comb begin
    d_idx        = d_in_source[4 +: IDX_W];
    d_ok         = int'(d_idx) < N_REQ;
    d_out_source = d_in_source[3:0];
    d_out_valid  = '0;
    d_in_ready   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (d_ok && d_idx == IDX_W'(i)) begin
        d_out_valid[i] = d_in_valid;
        d_in_ready     = d_out_ready[i];
      end
    end
    d_fire  = d_in_valid && d_in_ready;
    d_beats = dd_beats(d_in_opcode, d_in_size);
    d_cnt_d = d_cnt_q;
    d_last  = 1'b0;
    if (d_fire) begin
      if (d_cnt_q == 6'd0) begin
        d_last  = (d_beats == 6'd1);
        d_cnt_d = d_beats - 6'd1;
      end else begin
        d_last  = (d_cnt_q == 6'd1);
        d_cnt_d = d_cnt_q - 6'd1;
      end
    end
  end

  // Outstanding counters: A-last increments, D-last decrements, both together cancel.
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      inc          = a_last && (grant == IDX_W'(i));
      dec          = d_last && (d_idx == IDX_W'(i));
      out_cnt_d[i] = out_cnt_q[i];
      ovf_err[i]   = 1'b0;
      unf_err[i]   = 1'b0;
      if (inc && !dec) begin
        if (out_cnt_q[i] >= 4'(MAX_OUT)) ovf_err[i] = 1'b1;
        else out_cnt_d[i] = out_cnt_q[i] + 4'd1;
      end else if (dec && !inc) begin
        if (out_cnt_q[i] == 4'd0) unf_err[i] = 1'b1;
        else out_cnt_d[i] = out_cnt_q[i] - 4'd1;
      end
    end
  end

  // Simulation checks on misuse: unroutable D index and counter overflow or underflow.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(d_in_valid && !d_ok)) else $fatal(1, "d_in_source index out of range");
      assert (ovf_err == '0) else $fatal(1, "outstanding counter overflow");
      assert (unf_err == '0) else $fatal(1, "outstanding counter underflow");
    end
  end

endmodule

// File: tb/tb_tl_a_arbiter_rr.sv
// Directed bench for tl_a_arbiter_rr with N_REQ=2 and MAX_OUT=4.
// Each expected A beat is pushed as {index, source, address} before it is driven.
// It is popped and compared when the merged A channel fires.
module tb_tl_a_arbiter_rr;

  localparam int N_REQ = 2;
  localparam int IDX_W = 1;

  logic                 clock, reset;
  logic [N_REQ-1:0]     a_in_valid, a_in_ready;
  logic [3*N_REQ-1:0]   a_in_opcode, a_in_size;
  logic [4*N_REQ-1:0]   a_in_source, a_in_mask;
  logic [30*N_REQ-1:0]  a_in_address;
  logic [32*N_REQ-1:0]  a_in_data;
  logic                 a_out_valid, a_out_ready;
  logic [2:0]           a_out_opcode, a_out_size;
  logic [4+IDX_W-1:0]   a_out_source;
  logic [29:0]          a_out_address;
  logic [3:0]           a_out_mask;
  logic [31:0]          a_out_data;
  logic                 d_in_valid, d_in_ready;
  logic [2:0]           d_in_opcode, d_in_size;
  logic [4+IDX_W-1:0]   d_in_source;
  logic [N_REQ-1:0]     d_out_valid, d_out_ready;
  logic [3:0]           d_out_source;
  logic [4*N_REQ-1:0]   outstanding;
  logic                 dbg_state;
  logic [IDX_W-1:0]     dbg_rr_ptr;

  logic [34:0] exp_q[$];
  int n_total, n_pass;

  tl_a_arbiter_rr #(.N_REQ(2), .MAX_OUT(4)) dut (
    .clock(clock), .reset(reset),
    .a_in_valid(a_in_valid), .a_in_ready(a_in_ready), .a_in_opcode(a_in_opcode),
    .a_in_size(a_in_size), .a_in_source(a_in_source), .a_in_address(a_in_address),
    .a_in_mask(a_in_mask), .a_in_data(a_in_data),
    .a_out_valid(a_out_valid), .a_out_ready(a_out_ready), .a_out_opcode(a_out_opcode),
    .a_out_size(a_out_size), .a_out_source(a_out_source), .a_out_address(a_out_address),
    .a_out_mask(a_out_mask), .a_out_data(a_out_data),
    .d_in_valid(d_in_valid), .d_in_ready(d_in_ready), .d_in_opcode(d_in_opcode),
    .d_in_size(d_in_size), .d_in_source(d_in_source),
    .d_out_valid(d_out_valid), .d_out_ready(d_out_ready), .d_out_source(d_out_source),
    .outstanding(outstanding), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver: program one requester's A fields.
  task automatic set_req(input int i, input logic v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [3:0] src, input logic [29:0] addr);
    a_in_valid[i]          = v;
    a_in_opcode[3*i +: 3]  = op;
    a_in_size[3*i +: 3]    = sz;
    a_in_source[4*i +: 4]  = src;
    a_in_address[30*i +: 30] = addr;
    a_in_mask[4*i +: 4]    = 4'hf;
    a_in_data[32*i +: 32]  = $urandom;
  endtask

  // Driver: present a D beat, or idle the D channel when v=0.
  task automatic set_d(input logic v, input logic [2:0] op, input logic [2:0] sz, input logic [4:0] src);
    d_in_valid  = v;
    d_in_opcode = op;
    d_in_size   = sz;
    d_in_source = src;
  endtask

  // Scoreboard: one clock cycle, comparing any merged A beat against the queue head.
  task automatic cycle();
    logic [34:0] e;
    @(negedge clock);
    if (a_out_valid && a_out_ready) begin
      if (exp_q.size() == 0) check("a_unexpected_fire", 64'({a_out_source, a_out_address}), 64'h0);
      else begin
        e = exp_q.pop_front();
        check("a_fire", 64'({a_out_source, a_out_address}), 64'(e));
      end
    end
    @(posedge clock);
    #1;
  endtask

  localparam logic [34:0] E0 = {1'b0, 4'h3, 30'h100};
  localparam logic [34:0] E1 = {1'b1, 4'h5, 30'h200};

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    a_in_valid = '0; a_in_opcode = '0; a_in_size = '0; a_in_source = '0;
    a_in_address = '0; a_in_mask = '0; a_in_data = '0;
    a_out_ready = 1'b1;
    set_d(1'b0, 3'd0, 3'd2, 5'h00);
    d_out_ready = 2'b11;
    #1;
    check("reset_a_out_valid", 64'(a_out_valid), 64'h0);
    check("reset_a_in_ready", 64'(a_in_ready), 64'h0);
    check("reset_outstanding", 64'(outstanding), 64'h0);
    check("reset_state", 64'(dbg_state), 64'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: two single-beat Get streams alternate 0,1,0,1
    set_req(0, 1'b1, 3'd4, 3'd2, 4'h3, 30'h100);
    set_req(1, 1'b1, 3'd4, 3'd2, 4'h5, 30'h200);
    #1;
    check("t1_ready_first", 64'(a_in_ready), 64'h1);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back((k % 2 == 0) ? E0 : E1);
      cycle();
    end
    a_in_valid = '0;
    #1;
    check("t1_outstanding", 64'(outstanding), 64'h22);
    check("t1_queue_empty", 64'(exp_q.size()), 64'h0);
    set_d(1'b1, 3'd0, 3'd2, 5'h03);
    #1;
    check("t1_d_route0", 64'({d_out_valid, d_out_source}), 64'h13);
    cycle();
    set_d(1'b1, 3'd0, 3'd2, 5'h15);
    #1;
    check("t1_d_route1", 64'({d_out_valid, d_out_source}), 64'h25);
    cycle();
    set_d(1'b1, 3'd0, 3'd2, 5'h03); cycle();
    set_d(1'b1, 3'd0, 3'd2, 5'h15); cycle();
    set_d(1'b0, 3'd0, 3'd2, 5'h00);
    #1;
    check("t1_drained", 64'(outstanding), 64'h0);

    // 2: 4-beat PutFull from req0 holds the grant, req1 follows on the 5th cycle
    set_req(0, 1'b1, 3'd0, 3'd4, 4'h3, 30'h100);
    set_req(1, 1'b1, 3'd4, 3'd2, 4'h5, 30'h200);
    for (int k = 0; k < 4; k++) exp_q.push_back(E0);
    exp_q.push_back(E1);
    cycle();
    check("t2_burst_state", 64'(dbg_state), 64'h1);
    check("t2_burst_ready", 64'(a_in_ready), 64'h1);
    for (int k = 0; k < 4; k++) cycle();
    a_in_valid = '0;
    #1;
    check("t2_queue_empty", 64'(exp_q.size()), 64'h0);
    check("t2_outstanding", 64'(outstanding), 64'h11);
    check("t2_idle", 64'(dbg_state), 64'h0);
    set_d(1'b1, 3'd0, 3'd2, 5'h03); cycle();
    set_d(1'b1, 3'd0, 3'd2, 5'h15); cycle();
    set_d(1'b0, 3'd0, 3'd2, 5'h00);

    // 3: req1 saturates at MAX_OUT, is blocked, and resumes one cycle after an ack
    set_req(1, 1'b1, 3'd4, 3'd2, 4'h5, 30'h200);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(E1);
      cycle();
    end
    #1;
    check("t3_blocked_valid", 64'(a_out_valid), 64'h0);
    check("t3_outstanding_max", 64'(outstanding), 64'h40);
    cycle();
    set_d(1'b1, 3'd0, 3'd2, 5'h12);
    #1;
    check("t3_still_blocked", 64'(a_out_valid), 64'h0);
    check("t3_d_ready", 64'(d_in_ready), 64'h1);
    cycle();
    set_d(1'b0, 3'd0, 3'd2, 5'h00);
    #1;
    check("t3_unblocked", 64'(a_out_valid), 64'h1);
    exp_q.push_back(E1);
    cycle();
    a_in_valid = '0;
    #1;
    check("t3_queue_empty", 64'(exp_q.size()), 64'h0);

    // 4: 2-beat AccessAckData decrements only after its second beat
    set_d(1'b1, 3'd1, 3'd3, 5'h13);
    #1;
    check("t4_route_b1", 64'(d_out_valid), 64'h2);
    cycle();
    check("t4_after_b1", 64'(outstanding), 64'h40);
    check("t4_route_b2", 64'(d_out_valid), 64'h2);
    cycle();
    check("t4_after_b2", 64'(outstanding), 64'h30);
    for (int k = 0; k < 3; k++) begin
      set_d(1'b1, 3'd0, 3'd2, 5'h10);
      cycle();
    end
    set_d(1'b0, 3'd0, 3'd2, 5'h00);
    #1;
    check("t4_drained", 64'(outstanding), 64'h0);

    // 5: reset during beat 2 of a 4-beat burst clears all state
    set_req(0, 1'b1, 3'd0, 3'd4, 4'h3, 30'h100);
    exp_q.push_back(E0);
    cycle();
    check("t5_in_burst", 64'(dbg_state), 64'h1);
    a_out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("t5_reset_state", 64'(dbg_state), 64'h0);
    check("t5_reset_ptr", 64'(dbg_rr_ptr), 64'h0);
    check("t5_reset_outstanding", 64'(outstanding), 64'h0);
    a_in_valid = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    a_out_ready = 1'b1;
    set_req(1, 1'b1, 3'd4, 3'd2, 4'h5, 30'h200);
    exp_q.push_back(E1);
    #1;
    cycle();
    a_in_valid = '0;
    set_req(0, 1'b1, 3'd4, 3'd2, 4'h3, 30'h100);
    exp_q.push_back(E0);
    cycle();
    a_in_valid = '0;
    #1;
    check("t5_queue_empty", 64'(exp_q.size()), 64'h0);
    check("t5_outstanding", 64'(outstanding), 64'h11);

    // 6: A-last and D-last for req0 in the same cycle leave its count unchanged
    set_req(0, 1'b1, 3'd4, 3'd2, 4'h3, 30'h100);
    set_d(1'b1, 3'd0, 3'd2, 5'h03);
    exp_q.push_back(E0);
    cycle();
    a_in_valid = '0;
    set_d(1'b0, 3'd0, 3'd2, 5'h00);
    #1;
    check("t6_outstanding", 64'(outstanding), 64'h11);
    check("t6_queue_empty", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
